tmds_video_timing_ctrl: RTL and testbench
=========================================

// Module: tmds_video_timing_ctrl
// PURPOSE
//  Raster sequencer for one tmds_encoder channel. Generates the h/v timing.
//  Drives disp_ena, control[1:0] = {vsync, hsync} and the 8-bit d_in for the
//  encoder, all aligned in the same cycle.
//  Pulls pixels from a show-ahead source (FIFO/line buffer) with a req/valid
//  handshake. Start/stop is frame-granular.
// PARAMETERS
//  H_ACTIVE  640  active pixels per line
//  H_FP      16   h front porch (clks)
//  H_SYNC    96   hsync width (clks)
//  H_BP      48   h back porch (clks)
//  V_ACTIVE  480  active lines per frame
//  V_FP      10   v front porch (lines)
//  V_SYNC    2    vsync width (lines)
//  V_BP      33   v back porch (lines)
//  HS_POL    0    hsync asserted level (0 = active-low)
//  VS_POL    0    vsync asserted level (0 = active-low)
// PORTS
//  clk          in   1   pixel clock
//  rst          in   1   synchronous reset, active-high
//  run          in   1   request video output
//  pix_data     in   8   source pixel, valid when pix_valid=1
//  pix_valid    in   1   source has pixel (show-ahead)
//  underrun_clr in   1   clear sticky underrun
//  tp_sel       in   1   select test pattern (TMDS_TEST_PATTERN_EN only)
//  pix_req      out  1   pops source this cycle (combinational from counters/state)
//  disp_ena     out  1   to encoder disp_ena (registered)
//  control      out  2   to encoder control; [0]=hsync, [1]=vsync (registered)
//  d_out        out  8   to encoder d_in (registered)
//  frame_start  out  1   1-clk pulse, first pixel of frame on outputs
//  underrun     out  1   sticky: pixel needed but pix_valid=0
//  busy         out  1   state != IDLE
// BEHAVIOUR
//  - Totals:
//    - H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP
//    - V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP
//  - h_cnt/v_cnt are 12-bit; both totals must be <= 4096.
//  - Counters:
//    - h_cnt wraps H_TOTAL-1 -> 0 and increments v_cnt.
//    - v_cnt wraps V_TOTAL-1 -> 0 at the last pixel of the last line.
//  - Decode of the current position, cycle N:
//    - act = h_cnt<H_ACTIVE && v_cnt<V_ACTIVE
//    - hs = H_ACTIVE+H_FP <= h_cnt < H_ACTIVE+H_FP+H_SYNC
//    - vs = V_ACTIVE+V_FP <= v_cnt < V_ACTIVE+V_FP+V_SYNC (whole lines)
//  - Outputs at cycle N+1; latency is 1 clk:
//    - disp_ena = act
//    - control = {vs ? VS_POL : ~VS_POL, hs ? HS_POL : ~HS_POL}
//    - d_out = act ? (pix_valid ? pix_data : 8'h00) : 8'h00
//  - pix_req = (state!=IDLE) && act. It is asserted regardless of pix_valid,
//    and the source pops on pix_req && pix_valid.
//  - Underrun:
//    - set on pix_req && !pix_valid; cleared by underrun_clr
//    - on the same cycle, set wins
//  - FSM:
//    - IDLE:
//      - counters held at 0
//      - outputs at the inactive pattern: disp_ena=0, d_out=0,
//        control={~VS_POL,~HS_POL} (2'b11 at defaults)
//      - IDLE -> RUN when run=1; counting starts at (0,0) that same cycle
//    - RUN:
//      - counting
//      - RUN -> DRAIN when run=0
//    - DRAIN:
//      - counting, the frame completes normally
//      - DRAIN -> RUN if run=1 again, with no gap and no counter reset
//      - DRAIN -> IDLE on wrap (H_TOTAL-1, V_TOTAL-1)
//      - frames are never truncated
//  - frame_start is 1 in cycle N+1 when state!=IDLE and position (0,0) in cycle N.
//  - rst forces IDLE, counters 0, underrun 0, frame_start 0 and outputs to the
//    inactive pattern. This is immediate, including mid-frame or mid-sync.
//  - The first output cycle after leaving IDLE carries pixel (0,0).
//    A back-to-back frame has no idle cycle at the wrap.
// CONFIGURATION
//  - TMDS_TEST_PATTERN_EN defined:
//    - while tp_sel=1: pix_req=0, underrun is not set,
//      d_out = h_cnt[7:0] ^ {8{v_cnt[4]}} during active
//    - tp_sel is sampled every cycle; switching takes effect at the next cycle
//  - TMDS_TEST_PATTERN_EN undefined: tp_sel is ignored; the port remains, unused.
// TESTING
//  Small timing: H_ACTIVE=8, H_FP=2, H_SYNC=3, H_BP=1 (H_TOTAL=14);
//  V_ACTIVE=4, V_FP=1, V_SYNC=2, V_BP=1 (V_TOTAL=8); polarities 0.
//  1. rst=1 for 3 clks, then run=0 for 10 clks
//     -> disp_ena=0, control=2'b11, d_out=0, busy=0, pix_req=0.
//  2. run=1 held, pix_valid=1, pix_data=h_cnt
//     -> per line, disp_ena high for 8 clks; d_out 0..7 one clk after pix_req;
//        control[0]=0 for exactly 3 clks starting 10 clks after the line start;
//        frame_start once per 112 clks.
//  3. pix_valid=0 for pixel 3 of line 0
//     -> d_out=8'h00 for that pixel, underrun=1 from the next clk and held;
//        underrun_clr together with a new underrun -> stays 1.
//  4. run dropped at clk 20 of a frame
//     -> the frame completes through clk 111; busy falls after the wrap;
//        run re-raised at clk 50 -> the next frame follows seamlessly.
//  5. rst pulsed during vsync (v_cnt=5)
//     -> next clk: control=2'b11, disp_ena=0, busy=0, underrun=0.
//  6. TMDS_TEST_PATTERN_EN with tp_sel=1
//     -> pix_req=0; d_out=h_cnt on lines 0-3; underrun never sets with pix_valid=0.

Source files
------------

// File: rtl/tmds_video_timing_ctrl.sv
// -----------------------------------------------------------------------------
// tmds_video_timing_ctrl
//
// Raster sequencer for one TMDS encoder channel. It generates horizontal and
// vertical timing and produces the encoder inputs disp_ena, control[1:0]
// ({vsync, hsync}) and the 8-bit pixel value d_out. All three are registered
// and aligned in the same cycle. Pixels are pulled from a show-ahead source
// with a req/valid handshake: the source pops on pix_req_o && pix_valid_i.
// Start and stop are frame-granular. Once a frame has started it always runs
// to completion.
//
// Optional feature macro: TMDS_TEST_PATTERN_EN
//   When this macro is defined, tp_sel_i selects an internal test pattern
//   (h_cnt[7:0] ^ {8{v_cnt[4]}}) and the pixel source is not popped. When it
//   is undefined, tp_sel_i is ignored.
//
// Ports
//   clk_i           pixel clock
//   rst_i           synchronous reset, active-high
//   run_i           request video output
//   pix_data_i[7:0] source pixel, valid when pix_valid_i=1
//   pix_valid_i     source has a pixel available (show-ahead)
//   underrun_clr_i  clears the sticky underrun flag
//   tp_sel_i        test pattern select (TMDS_TEST_PATTERN_EN builds only)
//   pix_req_o       pops the source this cycle (combinational)
//   disp_ena_o      encoder disp_ena (registered)
//   control_o[1:0]  encoder control, [0]=hsync, [1]=vsync (registered)
//   d_out_o[7:0]    encoder d_in (registered)
//   frame_start_o   1-clk pulse while the first pixel of a frame is on the outputs
//   underrun_o      sticky: a pixel was needed but pix_valid_i=0
//   busy_o          sequencer is not idle
// -----------------------------------------------------------------------------
module tmds_video_timing_ctrl #(
    parameter int   H_ACTIVE = 640,
    parameter int   H_FP     = 16,
    parameter int   H_SYNC   = 96,
    parameter int   H_BP     = 48,
    parameter int   V_ACTIVE = 480,
    parameter int   V_FP     = 10,
    parameter int   V_SYNC   = 2,
    parameter int   V_BP     = 33,
    parameter logic HS_POL   = 1'b0,
    parameter logic VS_POL   = 1'b0
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       run_i,
    input  logic [7:0] pix_data_i,
    input  logic       pix_valid_i,
    input  logic       underrun_clr_i,
    input  logic       tp_sel_i,
    output logic       pix_req_o,
    output logic       disp_ena_o,
    output logic [1:0] control_o,
    output logic [7:0] d_out_o,
    output logic       frame_start_o,
    output logic       underrun_o,
    output logic       busy_o
);

    // Both totals must not exceed 4096 so that the counters fit in 12 bits.
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [11:0] H_ACT_END = 12'(H_ACTIVE);
    localparam logic [11:0] H_SYNC_LO = 12'(H_ACTIVE + H_FP);
    localparam logic [11:0] H_SYNC_HI = 12'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [11:0] H_LAST    = 12'(H_TOTAL - 1);
    localparam logic [11:0] V_ACT_END = 12'(V_ACTIVE);
    localparam logic [11:0] V_SYNC_LO = 12'(V_ACTIVE + V_FP);
    localparam logic [11:0] V_SYNC_HI = 12'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [11:0] V_LAST    = 12'(V_TOTAL - 1);

    // Inactive control pattern: both syncs deasserted.
    localparam logic [1:0] CTRL_IDLE = {~VS_POL, ~HS_POL};

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [11:0] h_cnt_q, h_cnt_d;
    logic [11:0] v_cnt_q, v_cnt_d;
    logic        disp_ena_q, disp_ena_d;
    logic [1:0]  control_q, control_d;
    logic [7:0]  d_out_q, d_out_d;
    logic        frame_start_q, frame_start_d;
    logic        underrun_q, underrun_d;

    logic        running;
    logic        act;
    logic        hs;
    logic        vs;
    logic        h_wrap;
    logic        frame_end;
    logic        tp_active;
    logic [7:0]  pix_byte;

`ifdef TMDS_TEST_PATTERN_EN
    // tp_sel_i is registered so a switch only affects the following cycle.
    logic        tp_q;
    logic [7:0]  tp_byte;

    assign tp_active = tp_q;
    assign tp_byte   = h_cnt_q[7:0] ^ {8{v_cnt_q[4]}};
    assign pix_byte  = tp_q ? tp_byte : (pix_valid_i ? pix_data_i : 8'h00);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            tp_q <= 1'b0;
        end else begin
            tp_q <= tp_sel_i;
        end
    end
`else
    logic unused_tp_sel;

    assign unused_tp_sel = tp_sel_i;
    assign tp_active     = 1'b0;
    assign pix_byte      = pix_valid_i ? pix_data_i : 8'h00;
`endif

    // Position decode for the current cycle.
    assign running   = (state_q != S_IDLE);
    assign act       = (h_cnt_q < H_ACT_END) && (v_cnt_q < V_ACT_END);
    assign hs        = (h_cnt_q >= H_SYNC_LO) && (h_cnt_q < H_SYNC_HI);
    assign vs        = (v_cnt_q >= V_SYNC_LO) && (v_cnt_q < V_SYNC_HI);
    assign h_wrap    = (h_cnt_q == H_LAST);
    assign frame_end = h_wrap && (v_cnt_q == V_LAST);

    // The request is raised for every active position, independent of
    // pix_valid_i; a missing pixel is what the underrun flag records.
    assign pix_req_o = running && act && !tp_active;

    always_comb begin
        state_d = state_q;
        h_cnt_d = h_cnt_q;
        v_cnt_d = v_cnt_q;
        unique case (state_q)
            S_IDLE: begin
                h_cnt_d = 12'd0;
                v_cnt_d = 12'd0;
                if (run_i) begin
                    state_d = S_RUN;
                end
            end
            S_RUN, S_DRAIN: begin
                if (h_wrap) begin
                    h_cnt_d = 12'd0;
                    v_cnt_d = frame_end ? 12'd0 : v_cnt_q + 12'd1;
                end else begin
                    h_cnt_d = h_cnt_q + 12'd1;
                end
                // A re-raised run resumes without disturbing the counters;
                // otherwise stopping only happens at the frame wrap.
                if (run_i) begin
                    state_d = S_RUN;
                end else if ((state_q == S_DRAIN) && frame_end) begin
                    state_d = S_IDLE;
                end else begin
                    state_d = S_DRAIN;
                end
            end
            default: begin
                state_d = S_IDLE;
                h_cnt_d = 12'd0;
                v_cnt_d = 12'd0;
            end
        endcase
    end

    always_comb begin
        disp_ena_d    = running && act;
        control_d     = running ? {vs ? VS_POL : ~VS_POL, hs ? HS_POL : ~HS_POL}
                                : CTRL_IDLE;
        d_out_d       = (running && act) ? pix_byte : 8'h00;
        frame_start_d = running && (h_cnt_q == 12'd0) && (v_cnt_q == 12'd0);
        // Set has priority over clear so a simultaneous event is never lost.
        if (pix_req_o && !pix_valid_i) begin
            underrun_d = 1'b1;
        end else if (underrun_clr_i) begin
            underrun_d = 1'b0;
        end else begin
            underrun_d = underrun_q;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q       <= S_IDLE;
            h_cnt_q       <= 12'd0;
            v_cnt_q       <= 12'd0;
            disp_ena_q    <= 1'b0;
            control_q     <= CTRL_IDLE;
            d_out_q       <= 8'h00;
            frame_start_q <= 1'b0;
            underrun_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            h_cnt_q       <= h_cnt_d;
            v_cnt_q       <= v_cnt_d;
            disp_ena_q    <= disp_ena_d;
            control_q     <= control_d;
            d_out_q       <= d_out_d;
            frame_start_q <= frame_start_d;
            underrun_q    <= underrun_d;
        end
    end

    assign disp_ena_o    = disp_ena_q;
    assign control_o     = control_q;
    assign d_out_o       = d_out_q;
    assign frame_start_o = frame_start_q;
    assign underrun_o    = underrun_q;
    assign busy_o        = running;

endmodule

// File: tb/tb_tmds_video_timing_ctrl.sv
// Self-checking bench for tmds_video_timing_ctrl using a small raster
// (14 x 8 clocks per frame). The reference model tracks a linear frame
// position 0..111 and derives h/v, sync windows and outputs arithmetically.
module tb_tmds_video_timing_ctrl;

    localparam int HA = 8, HF = 2, HSW = 3, HB = 1;
    localparam int VA = 4, VF = 1, VSW = 2, VB = 1;
    localparam int HT = HA + HF + HSW + HB;
    localparam int VT = VA + VF + VSW + VB;
    localparam int FT = HT * VT;
    localparam logic HP = 1'b0;
    localparam logic VP = 1'b0;

    logic       clk = 1'b0;
    logic       rst, run, pix_valid, underrun_clr, tp_sel;
    logic [7:0] pix_data;
    logic       pix_req, disp_ena, frame_start, underrun, busy;
    logic [1:0] control;
    logic [7:0] d_out;

    tmds_video_timing_ctrl #(
        .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HSW), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VSW), .V_BP(VB),
        .HS_POL(HP), .VS_POL(VP)
    ) dut (
        .clk_i(clk), .rst_i(rst), .run_i(run),
        .pix_data_i(pix_data), .pix_valid_i(pix_valid),
        .underrun_clr_i(underrun_clr), .tp_sel_i(tp_sel),
        .pix_req_o(pix_req), .disp_ena_o(disp_ena), .control_o(control),
        .d_out_o(d_out), .frame_start_o(frame_start),
        .underrun_o(underrun), .busy_o(busy)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;
    int fs_count = 0;

    // Reference model state.
    bit         m_on = 0;     // video running
    bit         m_stop = 0;   // run was low on the previous cycle
    bit         m_tp = 0;     // test pattern selected (sampled last cycle)
    bit         m_und = 0;
    bit         m_fs = 0;
    bit         m_disp = 0;
    logic [1:0] m_ctl = {~VP, ~HP};
    logic [7:0] m_dout = 8'h00;
    int         m_pos = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic bit req_now();
        int h, v;
        bit r;
        h = m_pos % HT;
        v = m_pos / HT;
        r = m_on && (h < HA) && (v < VA);
`ifdef TMDS_TEST_PATTERN_EN
        r = r && !m_tp;
`endif
        return r;
    endfunction

    // Compare the DUT against the model for the current cycle, then advance
    // both across one clock edge using the inputs currently driven.
    task automatic tick();
        int h, v;
        bit a, hs_w, vs_w, req;
        logic [7:0] pat;
        check("pix_req", pix_req, req_now());
        check("busy", busy, m_on);
        check("disp_ena", disp_ena, m_disp);
        check("control", control, m_ctl);
        check("d_out", d_out, m_dout);
        check("frame_start", frame_start, m_fs);
        check("underrun", underrun, m_und);
        if (frame_start === 1'b1) fs_count++;

        h    = m_pos % HT;
        v    = m_pos / HT;
        a    = (h < HA) && (v < VA);
        hs_w = (h >= HA + HF) && (h < HA + HF + HSW);
        vs_w = (v >= VA + VF) && (v < VA + VF + VSW);
        req  = req_now();
        pat  = 8'(h);
        if (((v >> 4) & 1) == 1) pat = ~pat;

        @(posedge clk);
        if (rst) begin
            m_on = 0; m_pos = 0; m_stop = 0; m_tp = 0; m_und = 0;
            m_fs = 0; m_disp = 0; m_ctl = {~VP, ~HP}; m_dout = 8'h00;
        end else begin
            if (m_on) begin
                m_disp = a;
                m_ctl  = {vs_w ? VP : ~VP, hs_w ? HP : ~HP};
                if (!a)            m_dout = 8'h00;
                else if (m_tp)     m_dout = pat;
                else if (pix_valid) m_dout = pix_data;
                else               m_dout = 8'h00;
                m_fs = (m_pos == 0);
            end else begin
                m_disp = 0; m_ctl = {~VP, ~HP}; m_dout = 8'h00; m_fs = 0;
            end
            if (req && !pix_valid) m_und = 1;
            else if (underrun_clr) m_und = 0;
`ifdef TMDS_TEST_PATTERN_EN
            m_tp = tp_sel;
`endif
            if (!m_on) begin
                if (run) begin m_on = 1; m_pos = 0; m_stop = 0; end
            end else if (m_pos == FT - 1 && m_stop && !run) begin
                m_on = 0; m_pos = 0;
            end else begin
                m_pos  = (m_pos + 1) % FT;
                m_stop = !run;
            end
        end
        #1;
    endtask

    // Advance until the model reaches a frame position, bounded.
    task automatic run_to_pos(input int p);
        int n;
        n = 0;
        while (!(m_on && m_pos == p) && n < 400) begin
            pix_data = 8'(m_pos % HT);
            tick();
            n++;
        end
        check("wait_pos_timeout", (n < 400), 1);
    endtask

    initial begin
        int cnt;
        rst = 1; run = 0; pix_valid = 0; pix_data = 8'h00;
        underrun_clr = 0; tp_sel = 0;
        @(posedge clk); #1;

        // 1: reset then idle
        repeat (3) tick();
        rst = 0;
        repeat (10) tick();
        check("idle_control", control, 2'b11);

        // 2: continuous video, pixel data = h position
        run = 1; pix_valid = 1;
        fs_count = 0;
        for (int i = 0; i < 2 * FT + 1; i++) begin
            pix_data = 8'(m_pos % HT);
            tick();
        end
        check("frame_start_count", fs_count, 2);

        // 3: underrun on pixel 3 of line 0, then set-vs-clear collision
        run_to_pos(3);
        pix_valid = 0; pix_data = 8'h5A; tick();
        pix_valid = 1;
        run_to_pos(20);
        check("underrun_held", underrun, 1);
        pix_valid = 0; underrun_clr = 1; tick();
        pix_valid = 1; underrun_clr = 0; tick();
        check("underrun_set_wins", underrun, 1);
        run_to_pos(30);
        underrun_clr = 1; tick();
        underrun_clr = 0; tick();
        check("underrun_cleared", underrun, 0);

        // 4: run dropped at clk 20 -> frame completes
        run_to_pos(20);
        run = 0;
        cnt = 0;
        while (m_on && cnt < 200) begin
            pix_data = 8'(m_pos % HT);
            tick();
            cnt++;
        end
        check("drain_length", cnt, FT - 20);
        check("busy_after_drain", busy, 0);
        repeat (5) tick();
        run = 1;
        run_to_pos(20);
        run = 0;
        run_to_pos(50);
        run = 1;
        for (int i = 0; i < FT; i++) begin
            pix_data = 8'(m_pos % HT);
            tick();
        end
        check("busy_rerun", busy, 1);

        // 5: reset during vsync
        run_to_pos(5 * HT + 3);
        rst = 1; tick();
        rst = 0;
        check("rst_control", control, 2'b11);
        check("rst_busy", busy, 0);
        check("rst_underrun", underrun, 0);
        run = 0;
        repeat (4) tick();

`ifdef TMDS_TEST_PATTERN_EN
        // 6: test pattern, source starved
        tp_sel = 1; pix_valid = 0; run = 1;
        for (int i = 0; i < FT + 10; i++) tick();
        check("tp_no_underrun", underrun, 0);
        tp_sel = 0; pix_valid = 1;
        repeat (3) tick();
`endif

        // Randomized phase
        for (int i = 0; i < 1500; i++) begin
            run          = ($urandom_range(0, 15) != 0);
            pix_valid    = ($urandom_range(0, 7) != 0);
            pix_data     = 8'($urandom);
            underrun_clr = ($urandom_range(0, 9) == 0);
            rst          = ($urandom_range(0, 299) == 0);
            tp_sel       = ($urandom_range(0, 3) == 0);
            tick();
        end
        rst = 0; run = 0; underrun_clr = 0;
        repeat (3) tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
